// File: rtl/uart_frame_pkg.sv
// Shared definitions for the framed-message receiver: FSM state encoding,
// error-vector bit positions, CRC-32 constants and the byte-wise CRC step.
package uart_frame_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_OPT   = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_CRC   = 3'd4,
    ST_CHECK = 3'd5,
    ST_DRAIN = 3'd6
  } state_e;

  // Bit positions inside the o_err pulse vector.
  localparam int ERR_W       = 5;
  localparam int ERR_CRC     = 0;
  localparam int ERR_LEN     = 1;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_FRAMING = 3;
  localparam int ERR_OVERRUN = 4;

  // CRC-32 IEEE, reflected form.
  localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

  // Advance a reflected CRC-32 by one byte; the loop unrolls into 8
  // shift/xor stages of pure combinational logic.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: simple dual-port RAM with synchronous write and a
// registered read port. The read register holds its value when rd_en_i is
// low so the streamed byte stays stable under back-pressure.
module uart_frame_buf #(
  parameter int DEPTH = 255,
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port.
  // NOTE: the storage array has no reset; only control state and the read
  // register are reset, which keeps the array mappable onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port, cleared by reset so the output byte starts at 0.
  // NOTE: clocked state is always assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed-message receiver: hunts for SYNC, parses OPT/LEN, buffers the
// payload, checks the CRC-32 trailer and streams clean frames out over a
// valid/ready interface with one-cycle error pulses.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int                    BYTE_SIZE   = 8,
  parameter int                    MAX_LEN     = 255,
  parameter logic [BYTE_SIZE-1:0]  SYNC_BYTE   = 'h7E,
  parameter bit                    CRC_EN      = 1'b1,
  parameter int                    TIMEOUT_CYC = 100000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  input  logic [BYTE_SIZE-1:0] in_data,
  input  logic                 in_err,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [BYTE_SIZE-1:0] o_data,
  output logic                 o_last,
  output logic [BYTE_SIZE-1:0] o_opt,
  output logic [BYTE_SIZE-1:0] o_len,
  output logic [ERR_W-1:0]     o_err,
  output logic                 o_busy
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e               state_q,   state_d;
  logic [BYTE_SIZE-1:0] cnt_q,     cnt_d;      // payload / trailer byte index
  logic [BYTE_SIZE-1:0] rd_cnt_q,  rd_cnt_d;   // buffer reads issued
  logic [BYTE_SIZE-1:0] opt_q,     opt_d;
  logic [BYTE_SIZE-1:0] len_q,     len_d;
  logic [31:0]          crc_q,     crc_d;
  logic [31:0]          rx_crc_q,  rx_crc_d;
  logic [TMO_W-1:0]     tmo_q,     tmo_d;
  logic [ERR_W-1:0]     err_q,     err_d;
  logic                 valid_q,   valid_d;
  logic                 last_q,    last_d;
  logic [BYTE_SIZE-1:0] opt_out_q, opt_out_d;
  logic [BYTE_SIZE-1:0] len_out_q, len_out_d;

  logic                 wr_en;
  logic                 rd_en;
  logic [BYTE_SIZE-1:0] rd_data;
  logic [7:0]           crc_byte;
  logic                 crc_ok;
  logic                 timed;
  logic                 tmo_hit;
  logic                 issue;

  assign crc_byte = 8'(in_data);
  assign crc_ok   = ((crc_q ^ CRC_XOROUT) == rx_crc_q);
  assign timed    = state_q inside {ST_OPT, ST_LEN, ST_DATA, ST_CRC};
  assign tmo_hit  = (TIMEOUT_CYC != 0) && timed && (tmo_q == TMO_LAST);

  // A buffer read is issued on a CHECK match (so the first byte lands two
  // cycles after the last CRC strobe) and in DRAIN whenever the output
  // register is empty or being consumed; this gives 1 byte/cycle at full
  // ready and freezes the output while stalled.
  assign issue = ((state_q == ST_CHECK) && crc_ok) ||
                 ((state_q == ST_DRAIN) && (rd_cnt_q != len_q) &&
                  (!valid_q || o_ready));

  // Next-state, datapath and output-stage control.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    opt_d     = opt_q;
    len_d     = len_q;
    crc_d     = crc_q;
    rx_crc_d  = rx_crc_q;
    opt_out_d = opt_out_q;
    len_out_d = len_out_q;
    valid_d   = valid_q;
    last_d    = last_q;
    err_d     = '0;
    tmo_d     = '0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;

    if (timed && !in_valid) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    unique case (state_q)
      ST_HUNT: begin
        if (in_valid && (in_data == SYNC_BYTE)) begin
          state_d = ST_OPT;
        end
      end

      ST_OPT, ST_LEN, ST_DATA, ST_CRC: begin
        // Priority: framing error, then a byte, then the timeout.
        if (in_err) begin
          err_d[ERR_FRAMING] = 1'b1;
          state_d            = ST_HUNT;
        end else if (in_valid) begin
          unique case (state_q)
            ST_OPT: begin
              opt_d   = in_data;
              state_d = ST_LEN;
            end
            ST_LEN: begin
              if ((in_data == '0) || (in_data > BYTE_SIZE'(MAX_LEN))) begin
                err_d[ERR_LEN] = 1'b1;
                state_d        = ST_HUNT;
              end else begin
                len_d    = in_data;
                cnt_d    = '0;
                rd_cnt_d = '0;
                crc_d    = CRC_INIT;
                state_d  = ST_DATA;
              end
            end
            ST_DATA: begin
              wr_en = 1'b1;
              crc_d = crc32_byte(crc_q, crc_byte);
              if (cnt_q == len_q - BYTE_SIZE'(1)) begin
                cnt_d = '0;
                if (CRC_EN) begin
                  state_d = ST_CRC;
                end else begin
                  // Without a trailer the frame is accepted here.
                  opt_out_d = opt_q;
                  len_out_d = len_q;
                  state_d   = ST_DRAIN;
                end
              end else begin
                cnt_d = cnt_q + BYTE_SIZE'(1);
              end
            end
            default: begin  // ST_CRC: trailer arrives LSB first
              rx_crc_d = {crc_byte, rx_crc_q[31:8]};
              if (cnt_q == BYTE_SIZE'(3)) begin
                state_d = ST_CHECK;
              end else begin
                cnt_d = cnt_q + BYTE_SIZE'(1);
              end
            end
          endcase
        end else if (tmo_hit) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_HUNT;
        end
      end

      ST_CHECK: begin
        if (crc_ok) begin
          opt_out_d = opt_q;
          len_out_d = len_q;
          state_d   = ST_DRAIN;
        end else begin
          err_d[ERR_CRC] = 1'b1;
          state_d        = ST_HUNT;
        end
      end

      ST_DRAIN: begin
        // The buffer is busy; a new byte cannot be stored.
        if (in_valid) begin
          err_d[ERR_OVERRUN] = 1'b1;
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // Output register: consume on handshake, refill on issue.
    if (valid_q && o_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (last_q) begin
        state_d = ST_HUNT;
      end
    end
    if (issue) begin
      rd_en    = 1'b1;
      rd_cnt_d = rd_cnt_q + BYTE_SIZE'(1);
      valid_d  = 1'b1;
      last_d   = (rd_cnt_q == len_q - BYTE_SIZE'(1));
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_HUNT;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      opt_q     <= '0;
      len_q     <= '0;
      crc_q     <= '0;
      rx_crc_q  <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      opt_out_q <= '0;
      len_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      opt_q     <= opt_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      rx_crc_q  <= rx_crc_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      opt_out_q <= opt_out_d;
      len_out_q <= len_out_d;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .WIDTH (BYTE_SIZE),
    .AW    (AW)
  ) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en_i   (wr_en),
    .wr_addr_i (cnt_q[AW-1:0]),
    .wr_data_i (in_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_cnt_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_data  = rd_data;
  assign o_opt   = opt_out_q;
  assign o_len   = len_out_q;
  assign o_err   = err_q;
  assign o_busy  = (state_q != ST_HUNT);

endmodule
